// File: rtl/seq_mult_deser.sv
// rtl/seq_mult_deser.sv - reassembles LSB-first product digits into a sign-extended parallel word
module seq_mult_deser #(
  parameter int P         = 2,
  parameter int MAX_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [$clog2(MAX_WIDTH/P):0]    bitSize,
  input  logic [P-1:0]                    p,
  input  logic                            newOut,
  input  logic                            done,
  output logic [2*MAX_WIDTH-1:0]          prod,
  output logic                            prod_valid,
  input  logic                            prod_ready,
  output logic                            busy,
  output logic                            len_err,
  output logic                            overrun
);

  localparam int W     = 2 * MAX_WIDTH;
  localparam int SLOTS = W / P;
  localparam int NW    = $clog2(MAX_WIDTH/P) + 1;
  localparam int CW    = NW + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;

  logic [1:0]    state;
  logic [NW-1:0] n_lat;
  logic [CW-1:0] cnt;
  logic [W-1:0]  shreg;

  logic [CW-1:0] frame_len;
  logic          take;
  logic          extra;
  logic [CW-1:0] cnt_next;
  logic [W-1:0]  sh_next;
  logic [W-1:0]  prod_next;
  logic          sign;
  logic          len_bad;
  int            top;

  assign frame_len = {n_lat, 1'b0};
  assign take      = (state == S_COLLECT) && newOut && (cnt != frame_len);
  assign extra     = (state == S_COLLECT) && newOut && (cnt == frame_len);
  assign cnt_next  = take ? cnt + CW'(1) : cnt;
  assign len_bad   = extra || (cnt_next != frame_len);
  assign top       = int'(frame_len) * P;
  assign busy      = (state == S_COLLECT);

  // The digit arriving alongside done is folded in before the word is closed.
  always_comb begin
    sh_next = shreg;
    if (take && (int'(cnt) < SLOTS))
      sh_next[int'(cnt)*P +: P] = p;
  end

  always_comb begin
    sign      = 1'b0;
    prod_next = '0;
    if (top >= 1 && top <= W)
      sign = sh_next[top-1];
    for (int i = 0; i < W; i++)
      prod_next[i] = (i < top) ? sh_next[i] : sign;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      n_lat      <= '0;
      cnt        <= '0;
      shreg      <= '0;
      prod       <= '0;
      prod_valid <= 1'b0;
      len_err    <= 1'b0;
      overrun    <= 1'b0;
    end else if (start) begin
      n_lat      <= bitSize;
      cnt        <= '0;
      shreg      <= '0;
      prod_valid <= 1'b0;
      overrun    <= 1'b0;
      if (bitSize == '0) begin
        state   <= S_IDLE;
        len_err <= 1'b1;
      end else begin
        state   <= S_COLLECT;
        len_err <= 1'b0;
      end
    end else begin
      case (state)
        S_COLLECT: begin
          shreg <= sh_next;
          cnt   <= cnt_next;
          if (extra)
            len_err <= 1'b1;
          if (done) begin
            prod       <= prod_next;
            prod_valid <= 1'b1;
            state      <= S_HOLD;
            if (len_bad)
              len_err <= 1'b1;
          end
        end
        S_HOLD: begin
          if (newOut || done)
            overrun <= 1'b1;
          if (prod_ready) begin
            prod_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
